// File: rtl/mips_fetch_pkg.sv
// Shared fetch definitions: FSM state encoding,
// reset PC and the NOP word used for misaligned fetches.
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the PC, issues one imem request at a time
// and hands each fetched word to decode over a valid/ready channel.
// Ports: clk/reset (async, active low); next_pc/redirect/redirect_pc
// in; pc out; imem req (valid/ready/addr) and rsp (valid/data);
// decode channel (instr_valid/instr_ready/instr/instr_pc/misalign).
module ifu_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         mis_q, mis_d;
  logic         pc_bad;
  logic         req_hs;

  assign pc_bad = (pc_q[1:0] != 2'b00);

  // A misaligned PC never reaches memory.
  assign imem_req_valid = (state_q == ST_REQ) && !pc_bad;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instr_valid    = (state_q == ST_HOLD);
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign misalign       = mis_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    mis_d   = mis_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (pc_bad) begin
          instr_d = INSTR_NOP;
          ipc_d   = pc_q;
          mis_d   = 1'b1;
          state_d = ST_HOLD;
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = req_hs ? ST_DROP : ST_REQ;
        end else if (req_hs) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          // Response already drained this cycle: refetch directly.
          state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          ipc_d   = pc_q;
          mis_d   = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (instr_ready) begin
          pc_d    = next_pc;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= INSTR_NOP;
      ipc_q   <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a 1-cycle memory model,
// +4 next-PC logic and a scoreboard of expected decode words.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  logic        mem_auto;
  logic        mem_v;
  logic [31:0] mem_d;
  logic        man_v;
  logic [31:0] man_d;
  int          cyc;
  int          last_cyc;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign next_pc        = pc + 32'd4;
  assign imem_rsp_valid = mem_v | man_v;
  assign imem_rsp_data  = man_v ? man_d : mem_d;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_v <= 1'b0;
      mem_d <= 32'h0;
    end else begin
      mem_v <= 1'b0;
      if (mem_auto && imem_req_valid && imem_req_ready) begin
        mem_v <= 1'b1;
        mem_d <= mem_word(imem_addr);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  ifu_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .misalign      (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic m);
    exp_t e;
    e.pc = a;
    e.data = d;
    e.mis = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_instr(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    if (instr_valid === 1'b1) begin
      chk({tag, "_sb_nonempty"}, {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, "_pc"}, instr_pc, e.pc);
        chk({tag, "_instr"}, instr, e.data);
        chk({tag, "_mis"}, {31'b0, misalign}, {31'b0, e.mis});
      end
      last_cyc = cyc;
    end
  endtask

  initial begin
    int c0;
    cyc = 0;
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    mem_auto = 1'b1;
    man_v = 1'b0;
    man_d = 32'h0;
    step();
    step();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    chk("rst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_ival", {31'b0, instr_valid}, 32'd0);

    reset = 1'b1;
    step();
    chk("rel_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rel_addr", imem_addr, 32'h3000);
    push(32'h3000, mem_word(32'h3000), 1'b0);
    push(32'h3004, mem_word(32'h3004), 1'b0);
    wait_instr("f3000");
    c0 = last_cyc;
    step();
    instr_ready = 1'b0;
    wait_instr("f3004");
    chk("rate", last_cyc - c0, 32'd3);

    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
      chk("bp_ipc", instr_pc, 32'h3004);
      chk("bp_instr", instr, mem_word(32'h3004));
      chk("bp_pc", pc, 32'h3004);
      chk("bp_req", {31'b0, imem_req_valid}, 32'd0);
    end

    mem_auto = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("w_addr", imem_addr, 32'h3008);
    step();
    chk("w_req", {31'b0, imem_req_valid}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h3100;
    step();
    redirect = 1'b0;
    chk("drop_pc", pc, 32'h3100);
    chk("drop_req", {31'b0, imem_req_valid}, 32'd0);
    man_v = 1'b1;
    man_d = mem_word(32'h3008);
    step();
    man_v = 1'b0;
    chk("drop_ival", {31'b0, instr_valid}, 32'd0);
    chk("rd_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rd_addr", imem_addr, 32'h3100);
    mem_auto = 1'b1;
    push(32'h3100, mem_word(32'h3100), 1'b0);
    wait_instr("f3100");

    mem_auto = 1'b0;
    step();
    chk("c_addr", imem_addr, 32'h3104);
    step();
    man_v = 1'b1;
    man_d = mem_word(32'h3104);
    redirect = 1'b1;
    redirect_pc = 32'h3200;
    step();
    man_v = 1'b0;
    redirect = 1'b0;
    chk("c_req", {31'b0, imem_req_valid}, 32'd1);
    chk("c_addr2", imem_addr, 32'h3200);
    chk("c_ival", {31'b0, instr_valid}, 32'd0);
    mem_auto = 1'b1;
    push(32'h3200, mem_word(32'h3200), 1'b0);
    wait_instr("f3200");

    redirect = 1'b1;
    redirect_pc = 32'h3102;
    step();
    redirect = 1'b0;
    chk("m_pc", pc, 32'h3102);
    chk("m_req", {31'b0, imem_req_valid}, 32'd0);
    push(32'h3102, 32'h0, 1'b1);
    wait_instr("f3102");
    chk("m_req2", {31'b0, imem_req_valid}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h3300;
    step();
    redirect = 1'b0;

    mem_auto = 1'b0;
    chk("r_addr", imem_addr, 32'h3300);
    step();
    #3;
    reset = 1'b0;
    #1;
    chk("ar_pc", pc, 32'h3000);
    chk("ar_req", {31'b0, imem_req_valid}, 32'd0);
    chk("ar_ival", {31'b0, instr_valid}, 32'd0);
    chk("ar_ipc", instr_pc, 32'h0);
    step();
    step();
    reset = 1'b1;
    man_v = 1'b1;
    man_d = mem_word(32'h3300);
    step();
    man_v = 1'b0;
    chk("ar_req2", {31'b0, imem_req_valid}, 32'd1);
    chk("ar_addr", imem_addr, 32'h3000);
    chk("ar_ival2", {31'b0, instr_valid}, 32'd0);
    mem_auto = 1'b1;
    push(32'h3000, mem_word(32'h3000), 1'b0);
    wait_instr("f3000b");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch controller that owns the program counter and drives the instruction-memory request/response channel. It presents `pc` to the next-PC logic, which returns `next_pc`. On each decode handshake it loads `next_pc`, or a later-stage `redirect_pc` when a redirect is asserted. It delivers one fetched instruction at a time to decode over a valid/ready handshake, with at most one memory request outstanding.

## Interface
- `RESET_PC`, 32'h0000_3000: PC loaded at reset.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `next_pc` in 32: sequential successor from next-PC logic; combinational from `pc`/`instr`.
- `redirect` in 1: taken branch/jump from a later stage; overrides everything.
- `redirect_pc` in 32: target, valid with `redirect`.
- `pc` out 32: current fetch PC; feeds next-PC logic.
- `imem_req_valid` out 1, `imem_req_ready` in 1, `imem_addr` out 32: request channel; `imem_addr == pc`.
- `imem_rsp_valid` in 1, `imem_rsp_data` in 32: response, one per accepted request, ≥1 cycle after acceptance.
- `instr_valid` out 1, `instr_ready` in 1, `instr` out 32, `instr_pc` out 32: decode channel.
- `misalign` out 1: qualifies `instr_valid`; PC had `pc[1:0] != 0`.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. Only `pc`, `instr`, `instr_pc`, `misalign` and state are registered.
- IDLE (reset state): always advances to REQ next cycle; no outputs asserted.
- REQ: `imem_req_valid=1`.
  - `pc[1:0]!=0` (checked first): no request issued; capture `instr=32'h0`, `instr_pc=pc`, `misalign=1`; go to HOLD.
  - Handshake: go to WAIT.
  - `redirect` without handshake: `pc<=redirect_pc`, stay in REQ. The address may change only on redirect.
  - `redirect` with handshake: `pc<=redirect_pc`, go to DROP.
- WAIT: request outstanding.
  - `imem_rsp_valid`: `instr<=imem_rsp_data`, `instr_pc<=pc`, `misalign<=0`; go to HOLD.
  - `redirect` without response: `pc<=redirect_pc`, go to DROP.
  - `redirect` with response: discard the data, `pc<=redirect_pc`, go to REQ.
- HOLD: `instr_valid=1`; `pc==instr_pc`, so next-PC logic sees the held instruction.
  - `redirect`: `pc<=redirect_pc`, go to REQ. Redirect beats `instr_ready`; the instruction counts as not consumed.
  - Else `instr_ready`: `pc<=next_pc`, go to REQ.
- DROP: waits to swallow the stale response.
  - `imem_rsp_valid`: discard it, go to REQ.
  - `redirect`: `pc<=redirect_pc`, stay in DROP.
- Adders and wrap-around live in the next-PC logic; 32'hFFFF_FFFC → 0 is accepted unchanged.

## Timing
- Reset (asynchronous, any state, including mid-request): state=IDLE, `pc=RESET_PC`, `instr=0`, `instr_pc=0`, `misalign=0`.
- In reset all handshake outputs are 0: `imem_req_valid=0`, `instr_valid=0`.
- A response arriving after reset is ignored (IDLE/REQ ignore `imem_rsp_valid`).
- Minimum fetch: REQ→WAIT→HOLD, so `instr_valid` rises 2 cycles after the REQ handshake with a 1-cycle memory.
- Peak throughput is 1 instruction per 3 cycles.
- `instr`, `instr_pc`, `misalign` are stable while `instr_valid=1` and no redirect occurs.
- `imem_req_valid` stays high in REQ until accepted.
- Redirect takes effect at the next clock edge. First request to `redirect_pc` is next cycle (from REQ/HOLD) or after the stale response drains (from WAIT/DROP).

## Structure
- Shared package `mips_fetch_pkg`:
  - state encoding `fetch_state_t`;
  - `FETCH_RESET_PC` (32'h0000_3000);
  - `INSTR_NOP` (32'h0).
- Single module; no sub-module. The PC register with its 3-way load mux (`RESET_PC`/`next_pc`/`redirect_pc`) stays inline.

## Test plan
- **Reset release:**
  - Stimulus: `imem_req_ready=1`, memory latency 1, `instr_ready=1`.
  - Required: `imem_addr=0x3000` one cycle after IDLE; then `instr_pc=0x3000`, `0x3004`, … every 3 cycles.
- **Decode backpressure:** hold `instr_ready=0` for 5 cycles in HOLD → `instr`/`instr_pc` constant, `pc` unchanged, no new request.
- **Redirect in WAIT:**
  - Stimulus: redirect to `0x3100` while the request for `0x3008` is outstanding.
  - Required: the `0x3008` response is dropped; next `imem_addr=0x3100`; decode never sees `0x3008`.
- **Redirect coincident with response in WAIT:** response data discarded; direct REQ to `redirect_pc` next cycle, no DROP.
- **Misaligned:** `redirect_pc=0x3102` → no memory request; `instr_valid=1`, `misalign=1`, `instr=0`, `instr_pc=0x3102`.
- **Reset mid-WAIT:** assert `reset` low asynchronously between edges → outputs cleared immediately; a late `imem_rsp_valid` after release is ignored; fetch restarts at `0x3000`.
